// File: rtl/alu_md_seq.sv
// ============================================================================
// Module   : alu_md_seq
// Purpose  : Iterative MUL/DIVU/REMU sequencer borrowing the EX-stage ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_md_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] ADD_OP = 3'd0,
    parameter logic [2:0] SUB_OP = 3'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [2:0]       ex_aluop,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_div;
    logic [WIDTH-1:0]     r_result;

    logic                 w_req_div;
    logic                 w_req_dz;
    logic                 w_is_div;
    logic                 w_last;
    logic [WIDTH:0]       w_rshift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_rem_nxt;

    assign w_req_div = (md_op == 2'd1) || (md_op == 2'd2);
    assign w_req_dz  = w_req_div && (src_b == '0);
    assign w_is_div  = (r_op == 2'd1) || (r_op == 2'd2);
    assign w_last    = (r_cnt == c_CNT_W'(1));

    // Shifted partial remainder keeps its carry bit so divisors above 2^(WIDTH-1)
    // still compare correctly; the ALU's WIDTH-bit difference is exact when taken.
    assign w_rshift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rshift >= {1'b0, r_div});
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_rem_nxt = w_ge ? alu_out : w_rshift[WIDTH-1:0];

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        alu_a       = ex_a;
        alu_b       = ex_b;
        alu_op      = ex_aluop;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    stall       = 1'b1;
                    w_state_nxt = w_req_dz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (w_is_div) begin
                    alu_op = SUB_OP;
                    alu_a  = w_rshift[WIDTH-1:0];
                    alu_b  = r_div;
                end else begin
                    alu_op = ADD_OP;
                    alu_a  = r_acc;
                    alu_b  = r_mplier[0] ? r_mcand : '0;
                end
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else if (!flush) begin
            if (r_state == S_IDLE && start) begin
                r_op     <= md_op;
                r_cnt    <= c_CNT_W'(WIDTH);
                r_acc    <= '0;
                r_mcand  <= src_a;
                r_mplier <= src_b;
                r_quo    <= src_a;
                r_rem    <= '0;
                r_div    <= src_b;
                if (w_req_dz) begin
                    r_result <= (md_op == 2'd1) ? '1 : src_a;
                end
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
                if (w_is_div) begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                end else begin
                    r_acc    <= alu_out;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end
                if (w_last) begin
                    if (!w_is_div) begin
                        r_result <= alu_out;
                    end else if (r_op == 2'd1) begin
                        r_result <= w_quo_nxt;
                    end else begin
                        r_result <= w_rem_nxt;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_md_seq.sv
// ============================================================================
// Module   : tb_alu_md_seq
// Purpose  : Scoreboard bench for alu_md_seq with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_md_seq;

    localparam int         W    = 32;
    localparam logic [2:0] ADDC = 3'd0;
    localparam logic [2:0] SUBC = 3'd1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   md_op = 2'd0;
    logic [W-1:0] src_a = '0, src_b = '0;
    logic [W-1:0] ex_a = '0, ex_b = '0;
    logic [2:0]   ex_aluop = 3'd0;
    logic [W-1:0] alu_a, alu_b, alu_out, result;
    logic [2:0]   alu_op;
    logic         stall, busy, done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the shared single-cycle ALU
    always_comb begin
        alu_out = alu_a ^ alu_b;
        if (alu_op == ADDC) alu_out = alu_a + alu_b;
        else if (alu_op == SUBC) alu_out = alu_a - alu_b;
    end

    alu_md_seq #(.WIDTH(W), .ADD_OP(ADDC), .SUB_OP(SUBC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .ex_a(ex_a), .ex_b(ex_b),
        .ex_aluop(ex_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .stall(stall), .busy(busy), .done(done),
        .result(result)
    );

    function automatic logic [W-1:0] ref_md(input logic [1:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (op == 2'd1) return (b == 0) ? {W{1'b1}} : a / b;
        if (op == 2'd2) return (b == 0) ? a : a % b;
        p = a * b;
        return p[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    // Caller is at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int lat;
        lat = ((op == 2'd1 || op == 2'd2) && b == 0) ? 1 : W + 1;
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        exp_q.push_back(ref_md(op, a, b));
        #1 chk("stall_c0", 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            chk("stall_run", 32'(stall), 32'd1);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("stall_done", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int           d0;
        int           n;
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ex_a = 32'd5; ex_b = 32'd3; ex_aluop = SUBC;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("pass_a", alu_a, 32'd5);
        chk("pass_b", alu_b, 32'd3);
        chk("pass_op", 32'(alu_op), 32'(SUBC));
        @(posedge clk); #1;

        run_op(2'd0, 32'd7, 32'd6);
        run_op(2'd0, 32'hFFFFFFFF, 32'd2);
        run_op(2'd1, 32'd100, 32'd7);
        run_op(2'd2, 32'd100, 32'd7);
        run_op(2'd1, 32'hFFFFFFFF, 32'd1);
        run_op(2'd1, 32'd9, 32'd0);
        run_op(2'd2, 32'd9, 32'd0);
        run_op(2'd3, 32'd12345, 32'd678);

        // Flush at cycle 10 of a MUL, then restart at cycle 11
        held = result;
        d0 = done_cnt;
        start = 1'b1; md_op = 2'd0; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, held);
        chk("flush_nodone", done_cnt, d0);
        run_op(2'd0, 32'd11, 32'd13);

        // Start held high: second acceptance at cycle 34, one done per request
        d0 = done_cnt;
        start = 1'b1; md_op = 2'd1; src_a = 32'd100; src_b = 32'd7;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd14);
        repeat (33) @(posedge clk);
        #1 chk("held_done33", 32'(done), 32'd1);
        chk("held_done_pass", alu_a, ex_a);
        @(posedge clk); #1;
        chk("held_c34_busy", 32'(busy), 32'd0);
        chk("held_c34_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_c35_busy", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_lat2", n, 32);
        @(posedge clk); #1;
        chk("held_count", done_cnt - d0, 2);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: begin rb = $urandom_range(1, 300); ra = $urandom_range(0, 5000); end
                1: rb = $urandom;
                2: rb = '0;
                default: rb = $urandom | 32'h8000_0000;
            endcase
            run_op(2'($urandom_range(0, 3)), ra, rb);
        end

        // Reset in the middle of RUN
        start = 1'b1; md_op = 2'd0; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
